alu_scheduler: RTL and testbench

Shares one combinational ALU between two requesters (for example, a switch/button front end and a test sequencer). Each request carries operands and an opcode, and is accepted through a valid/ready handshake. The block arbitrates round-robin, drives the ALU, waits a programmable settle time, captures the result and returns it to the winning requester. It sits between the input logic and the ALU instance, which stays purely combinational.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_scheduler_rr_arbiter2.sv | 43 ++++
 rtl/alu_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_alu_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU scheduler slice.
//   alu_op_t      : 3-bit ALU opcode carried by each request and sent to the ALU.
//   sched_state_t : scheduler FSM states.
// Result convention: ADD/SUB/DIV/MOD and the logic ops return an N-bit value
// zero-extended to 2N bits; MUL returns the full 2N-bit product.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } sched_state_t;

    // True for the opcodes that divide and therefore need a zero-divisor check.
    function automatic logic is_div_op(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Two-requester index to one-hot vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin arbiter.
// Ports:
//   req_valid  [1:0] in  : request lines, bit i from requester i.
//   last_grant       in  : requester that won most recently.
//   gnt              out : index of the winning requester.
//   gnt_valid        out : at least one request is present.
// A lone requester always wins; on a tie the requester that did not win last
// time gets the grant.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       gnt,
    output logic       gnt_valid
);

    // Grant selection from the request pattern and the previous winner.
    always_comb begin
        gnt       = 1'b0;
        gnt_valid = 1'b0;
        case (req_valid)
            2'b01: begin
                gnt       = 1'b0;
                gnt_valid = 1'b1;
            end
            2'b10: begin
                gnt       = 1'b1;
                gnt_valid = 1'b1;
            end
            2'b11: begin
                gnt       = ~last_grant;
                gnt_valid = 1'b1;
            end
            default: begin
                gnt       = 1'b0;
                gnt_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// -----------------------------------------------------------------------------
// alu_scheduler
// Shares one combinational ALU between two requesters. A request is accepted
// via valid/ready, its operands are held on the ALU for ALU_LAT cycles, the
// result is captured and returned to the owning requester via valid/ready.
// Only one operation is in flight at a time.
//
// Parameters:
//   N        operand width
//   ALU_LAT  settle cycles before sampling the ALU result (>= 1)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake
//   req_a/req_b/req_op  per-requester payload, slices [i*N +: N] / [i*3 +: 3]
//   rsp_valid/rsp_ready per-requester response handshake (one-hot valid)
//   rsp_result/carry/err captured response, held until the next capture
//   alu_a/alu_b/alu_op  operands driven to the external ALU
//   alu_result/carry    result returned by the external ALU
//   grant_cnt           (ALU_SCHED_STATS_EN only) two 8-bit saturating
//                       per-requester accept counters, slice [i*8 +: 8]
// Optional feature macro: ALU_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int ALU_LAT = 2
) (
    input  logic [0:0]     clk,
    input  logic [0:0]     rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    input  logic [5:0]     req_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [2*N-1:0] rsp_result,
    output logic [0:0]     rsp_carry,
    output logic [0:0]     rsp_err,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_op,
    input  logic [2*N-1:0] alu_result,
    input  logic [0:0]     alu_carry
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0]    grant_cnt
`endif
);

    // The counter is loaded with ALU_LAT-1 and the capture happens on the
    // cycle it reads zero, so EXEC lasts exactly ALU_LAT cycles.
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    sched_state_t   state_r;
    logic           last_grant_r;
    logic           owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N-1:0]   opa_r;
    logic [N-1:0]   opb_r;
    alu_op_t        op_r;

    logic           gnt_s;
    logic           gnt_any_s;
    logic [N-1:0]   sel_a_s;
    logic [N-1:0]   sel_b_s;
    alu_op_t        sel_op_s;
    logic           accept_s;
    logic           div_zero_s;

    rr_arbiter2 u_arb (
        .req_valid (req_valid),
        .last_grant(last_grant_r),
        .gnt       (gnt_s),
        .gnt_valid (gnt_any_s)
    );

    // Payload of the granted requester, handshake ready and accept decode.
    always_comb begin
        sel_a_s    = {N{1'b0}};
        sel_b_s    = {N{1'b0}};
        sel_op_s   = OP_ADD;
        req_ready  = 2'b00;
        accept_s   = 1'b0;
        div_zero_s = 1'b0;
        if (gnt_s) begin
            sel_a_s  = req_a[2*N-1:N];
            sel_b_s  = req_b[2*N-1:N];
            sel_op_s = alu_op_t'(req_op[5:3]);
        end else begin
            sel_a_s  = req_a[N-1:0];
            sel_b_s  = req_b[N-1:0];
            sel_op_s = alu_op_t'(req_op[2:0]);
        end
        // Ready is gated by rst so nothing is offered while reset is held.
        if ((state_r == IDLE) && !rst[0] && gnt_any_s) begin
            req_ready = onehot2(gnt_s);
            accept_s  = 1'b1;
        end else begin
            req_ready = 2'b00;
            accept_s  = 1'b0;
        end
        div_zero_s = is_div_op(sel_op_s) && (sel_b_s == {N{1'b0}});
    end

    assign alu_a  = opa_r;
    assign alu_b  = opb_r;
    assign alu_op = op_r;

    // Scheduler FSM: accept, settle, capture, respond.
    always_ff @(posedge clk) begin
        if (rst[0]) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            cnt_r        <= CNT_ZERO;
            opa_r        <= {N{1'b0}};
            opb_r        <= {N{1'b0}};
            op_r         <= OP_ADD;
            rsp_valid    <= 2'b00;
            rsp_result   <= {(2*N){1'b0}};
            rsp_carry    <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opa_r        <= sel_a_s;
                        opb_r        <= sel_b_s;
                        op_r         <= sel_op_s;
                        owner_r      <= gnt_s;
                        last_grant_r <= gnt_s;
                        cnt_r        <= CNT_LOAD;
                        if (div_zero_s) begin
                            // Division by zero never reaches the ALU sample point.
                            rsp_result <= {(2*N){1'b1}};
                            rsp_carry  <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= onehot2(gnt_s);
                            state_r    <= RESP;
                        end else begin
                            state_r    <= EXEC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_r == CNT_ZERO) begin
                        rsp_result <= alu_result;
                        rsp_carry  <= alu_carry;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= onehot2(owner_r);
                        state_r    <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RESP: begin
                    // Only the owner's ready bit completes the response.
                    if (rsp_ready[owner_r]) begin
                        rsp_valid <= 2'b00;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    // Per-requester saturating accept counters.
    always_ff @(posedge clk) begin
        if (rst[0]) begin
            grant_cnt <= 16'h0000;
        end else if (accept_s) begin
            if (gnt_s) begin
                if (grant_cnt[15:8] != 8'hFF) begin
                    grant_cnt[15:8] <= grant_cnt[15:8] + 8'd1;
                end
            end else begin
                if (grant_cnt[7:0] != 8'hFF) begin
                    grant_cnt[7:0] <= grant_cnt[7:0] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_scheduler
// Self-checking bench for alu_scheduler (N=4, ALU_LAT=2) with a behavioural
// ALU attached. Covers reset, a vector table, arbitration ties, divide by
// zero, response backpressure, reset mid-operation and randomized traffic.
// With ALU_SCHED_STATS_EN defined it also checks the accept counters.
// -----------------------------------------------------------------------------
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int N       = 4;
    localparam int ALU_LAT = 2;

    logic [0:0]     clk;
    logic [0:0]     rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [2*N-1:0] rsp_result;
    logic [0:0]     rsp_carry;
    logic [0:0]     rsp_err;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [2*N-1:0] alu_result;
    logic [0:0]     alu_carry;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]    grant_cnt;
`endif

    int checks;
    int failures;
    int last_served;

    alu_scheduler #(.N(N), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_carry (alu_carry)
`ifdef ALU_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural combinational ALU.
    logic [N:0] sum_s;
    logic [N:0] dif_s;
    always_comb begin
        sum_s      = {1'b0, alu_a} + {1'b0, alu_b};
        dif_s      = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = {(2*N){1'b0}};
        alu_carry  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_result = {{N{1'b0}}, sum_s[N-1:0]};
                alu_carry  = sum_s[N];
            end
            OP_SUB: begin
                alu_result = {{N{1'b0}}, dif_s[N-1:0]};
                alu_carry  = dif_s[N];
            end
            OP_MUL: alu_result = {{N{1'b0}}, alu_a} * {{N{1'b0}}, alu_b};
            OP_DIV: alu_result = (alu_b == {N{1'b0}}) ? {(2*N){1'b1}} : {{N{1'b0}}, alu_a / alu_b};
            OP_MOD: alu_result = (alu_b == {N{1'b0}}) ? {(2*N){1'b1}} : {{N{1'b0}}, alu_a % alu_b};
            OP_AND: alu_result = {{N{1'b0}}, alu_a & alu_b};
            OP_OR:  alu_result = {{N{1'b0}}, alu_a | alu_b};
            OP_XOR: alu_result = {{N{1'b0}}, alu_a ^ alu_b};
            default: alu_result = {(2*N){1'b0}};
        endcase
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: expected result from the opcode rules, plain integers.
    task automatic model(input int op, input int a, input int b,
                         output int res, output int c, output int e, output int lat);
        res = 0; c = 0; e = 0; lat = ALU_LAT + 1;
        case (op)
            0: begin res = (a + b) % 16; c = ((a + b) >= 16) ? 1 : 0; end
            1: begin res = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: res = a * b;
            3: if (b == 0) begin res = 255; e = 1; lat = 1; end else res = a / b;
            4: if (b == 0) begin res = 255; e = 1; lat = 1; end else res = a % b;
            5: res = a & b;
            6: res = a | b;
            default: res = a ^ b;
        endcase
    endtask

    task automatic set_req(input int r, input int op, input int a, input int b);
        if (r == 0) begin
            req_a[N-1:0] = N'(a);   req_b[N-1:0] = N'(b);   req_op[2:0] = 3'(op);
        end else begin
            req_a[2*N-1:N] = N'(a); req_b[2*N-1:N] = N'(b); req_op[5:3] = 3'(op);
        end
        req_valid[r] = 1'b1;
    endtask

    // Expect an immediate grant to r, wait (bounded) for the accept edge.
    task automatic accept(input int r);
        int n;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << r));
        n = 0;
        while (!req_ready[r] && n < 20) begin
            step();
            n++;
        end
        if (!req_ready[r]) begin
            chk("accept_timeout", 32'(0), 32'(1));
        end else begin
            @(posedge clk);
            step();
            req_valid[r] = 1'b0;
        end
    endtask

    task automatic await_rsp(input int r, input int er, input int ec, input int ee, input int elat);
        int lat;
        lat = 1;
        chk("busy_ready", 32'(req_ready), 32'(0));
        while (rsp_valid == 2'b00 && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << r));
        chk("rsp_result", 32'(rsp_result), 32'(er));
        chk("rsp_carry", 32'(rsp_carry), 32'(ec));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
    endtask

    task automatic handshake(input int r, input int er);
        rsp_ready[r] = 1'b1;
        step();
        rsp_ready[r] = 1'b0;
        chk("rsp_clear", 32'(rsp_valid), 32'(0));
        chk("rsp_hold", 32'(rsp_result), 32'(er));
    endtask

    task automatic serve(input int r, input int er, input int ec, input int ee, input int elat);
        accept(r);
        await_rsp(r, er, ec, ee, elat);
        handshake(r, er);
        last_served = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        step();
        rst = 1'b0;
        last_served = 1;
    endtask

    typedef struct {
        int r; int op; int a; int b; int res; int c; int e; int lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int mask, win, lose;
        int op0, a0, b0, op1, a1, b1;
        int er, ec, ee, el;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_valid = 2'b11;
        req_a = 8'h5A; req_b = 8'h3C; req_op = 6'b010_001;
        rsp_ready = 2'b00;

        // Reset held with both requesters valid.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_req_ready", 32'(req_ready), 32'(0));
            chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("reset_rsp_result", 32'(rsp_result), 32'(0));
            chk("reset_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
        end
        rst = 1'b0;
        req_valid = 2'b00;
        last_served = 1;

        // Vector table.
        vecs[0]  = '{0, int'(OP_MUL), 15, 15, 'hE1, 0, 0, 3};
        vecs[1]  = '{1, int'(OP_ADD),  7,  9, 'h00, 1, 0, 3};
        vecs[2]  = '{1, int'(OP_DIV),  8,  0, 'hFF, 0, 1, 1};
        vecs[3]  = '{1, int'(OP_DIV),  8,  2, 'h04, 0, 0, 3};
        vecs[4]  = '{0, int'(OP_SUB),  3,  5, 'h0E, 1, 0, 3};
        vecs[5]  = '{0, int'(OP_MOD), 13,  4, 'h01, 0, 0, 3};
        vecs[6]  = '{1, int'(OP_OR),   9,  4, 'h0D, 0, 0, 3};
        vecs[7]  = '{0, int'(OP_XOR), 15,  5, 'h0A, 0, 0, 3};
        vecs[8]  = '{0, int'(OP_MOD),  7,  0, 'hFF, 0, 1, 1};
        vecs[9]  = '{1, int'(OP_AND), 12, 10, 'h08, 0, 0, 3};
        vecs[10] = '{1, int'(OP_SUB),  9,  2, 'h07, 0, 0, 3};
        vecs[11] = '{0, int'(OP_ADD),  8,  7, 'h0F, 0, 0, 3};
        for (int i = 0; i < 12; i++) begin
            set_req(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b);
            serve(vecs[i].r, vecs[i].res, vecs[i].c, vecs[i].e, vecs[i].lat);
        end

        // Ties after reset: req0 first, then req1, third tie back to req0.
        do_reset();
        set_req(0, int'(OP_AND), 12, 10);
        set_req(1, int'(OP_SUB), 3, 5);
        serve(0, 'h08, 0, 0, 3);
        serve(1, 'h0E, 1, 0, 3);
        set_req(0, int'(OP_XOR), 1, 2);
        set_req(1, int'(OP_OR), 1, 2);
        serve(0, 'h03, 0, 0, 3);
        serve(1, 'h03, 0, 0, 3);

        // Backpressure, with the non-owner's ready bit set (ignored).
        set_req(1, int'(OP_ADD), 5, 6);
        accept(1);
        await_rsp(1, 'h0B, 0, 0, 3);
        set_req(0, int'(OP_MUL), 3, 4);
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(2));
            chk("bp_rsp_result", 32'(rsp_result), 32'(8'h0B));
            chk("bp_req_ready", 32'(req_ready), 32'(0));
        end
        rsp_ready = 2'b00;
        handshake(1, 'h0B);
        last_served = 1;
        serve(0, 'h0C, 0, 0, 3);

        // Reset during EXEC discards the operation.
        set_req(0, int'(OP_MUL), 3, 3);
        accept(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_served = 1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("midrst_rsp_result", 32'(rsp_result), 32'(0));
        chk("midrst_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
        for (int i = 0; i < ALU_LAT + 3; i++) begin
            step();
            chk("midrst_no_rsp", 32'(rsp_valid), 32'(0));
        end
        set_req(0, int'(OP_ADD), 1, 1);
        serve(0, 'h02, 0, 0, 3);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            mask = $urandom_range(1, 3);
            op0 = $urandom_range(0, 7); a0 = $urandom_range(0, 15);
            b0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            op1 = $urandom_range(0, 7); a1 = $urandom_range(0, 15);
            b1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            if (mask[0]) set_req(0, op0, a0, b0);
            if (mask[1]) set_req(1, op1, a1, b1);
            if (mask == 3) win = 1 - last_served;
            else win = (mask == 1) ? 0 : 1;
            if (win == 0) model(op0, a0, b0, er, ec, ee, el);
            else model(op1, a1, b1, er, ec, ee, el);
            serve(win, er, ec, ee, el);
            if (mask == 3) begin
                lose = 1 - win;
                if (lose == 0) model(op0, a0, b0, er, ec, ee, el);
                else model(op1, a1, b1, er, ec, ee, el);
                serve(lose, er, ec, ee, el);
            end
        end

`ifdef ALU_SCHED_STATS_EN
        do_reset();
        chk("stats_reset", 32'(grant_cnt), 32'(0));
        for (int i = 0; i < 300; i++) begin
            set_req(0, int'(OP_ADD), 1, 2);
            serve(0, 'h03, 0, 0, 3);
        end
        chk("stats_req0_sat", 32'(grant_cnt[7:0]), 32'(255));
        chk("stats_req1", 32'(grant_cnt[15:8]), 32'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
